pipe_hazard_ctrl: RTL and testbench

//  Control-path sequencer for the 5-stage RISC-V pipeline. Takes decode-stage control

---
 rtl/pipe_hazard_ctrl_if.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Bus between the pipeline datapath and the hazard/control sequencer.
// The datapath is the master: it supplies the decode bundle and ZeroE.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ALUCTL_W = 3,
  parameter int unsigned CNT_W    = 16
);
  logic                RegWriteD;
  logic [1:0]          ResultSrcD;
  logic                MemWriteD;
  logic                JumpD;
  logic                BranchD;
  logic                AluSrcD;
  logic [ALUCTL_W-1:0] AluControlD;
  logic [REG_AW-1:0]   Rs1D;
  logic [REG_AW-1:0]   Rs2D;
  logic [REG_AW-1:0]   RdD;
  logic                ZeroE;

  logic                RegWriteE, RegWriteM, RegWriteW;
  logic [1:0]          ResultSrcE, ResultSrcM, ResultSrcW;
  logic                MemWriteE, MemWriteM;
  logic                AluSrcE;
  logic [ALUCTL_W-1:0] AluControlE;
  logic [REG_AW-1:0]   Rs1E, Rs2E;
  logic [REG_AW-1:0]   RdE, RdM, RdW;
  logic                PCSrcE;
  logic [1:0]          ForwardAE, ForwardBE;
  logic                StallF, StallD;
  logic                FlushD, FlushE;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    flush_cnt;

  modport master (
    output RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, AluSrcD, AluControlD,
           Rs1D, Rs2D, RdD, ZeroE,
    input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
           MemWriteE, MemWriteM, AluSrcE, AluControlE, Rs1E, Rs2E, RdE, RdM, RdW,
           PCSrcE, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, AluSrcD, AluControlD,
           Rs1D, Rs2D, RdD, ZeroE,
    output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
           MemWriteE, MemWriteM, AluSrcE, AluControlE, Rs1E, Rs2E, RdE, RdM, RdW,
           PCSrcE, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Control-path sequencer for a 5-stage RISC-V pipe: D->E->M->W control registers,
// load-use stall, branch/jump flush, E-stage forwarding selects and event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ALUCTL_W = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic                reg_write;
    logic [1:0]          result_src;
    logic                mem_write;
    logic                jump;
    logic                branch;
    logic                alu_src;
    logic [ALUCTL_W-1:0] alu_control;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [REG_AW-1:0]   rd;
  } e_stage_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic              mem_write;
    logic [REG_AW-1:0] rd;
  } m_stage_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic [REG_AW-1:0] rd;
  } w_stage_t;

  e_stage_t         e_q, e_d;
  m_stage_t         m_q;
  w_stage_t         w_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic             lw_stall;
  logic             pc_src;
  logic             flush_e;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  // M-stage producer wins over W-stage; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              rw_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              rw_w,
    input logic [REG_AW-1:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rw_m && (rd_m != '0) && (rs == rd_m)) begin
      sel = 2'b10;
    end else if (rw_w && (rd_w != '0) && (rs == rd_w)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    lw_stall = e_q.result_src[0] && (e_q.rd != '0) &&
               ((bus.Rs1D == e_q.rd) || (bus.Rs2D == e_q.rd));
    pc_src   = (e_q.branch && bus.ZeroE) || e_q.jump;
    flush_e  = lw_stall || pc_src;
    fwd_a    = fwd_sel(e_q.rs1, m_q.reg_write, m_q.rd, w_q.reg_write, w_q.rd);
    fwd_b    = fwd_sel(e_q.rs2, m_q.reg_write, m_q.rd, w_q.reg_write, w_q.rd);
  end

  // ID/EX next value: decode bundle, or a bubble when E is flushed.
  always_comb begin
    e_d = '0;
    if (!flush_e) begin
      e_d.reg_write   = bus.RegWriteD;
      e_d.result_src  = bus.ResultSrcD;
      e_d.mem_write   = bus.MemWriteD;
      e_d.jump        = bus.JumpD;
      e_d.branch      = bus.BranchD;
      e_d.alu_src     = bus.AluSrcD;
      e_d.alu_control = bus.AluControlD;
      e_d.rs1         = bus.Rs1D;
      e_d.rs2         = bus.Rs2D;
      e_d.rd          = bus.RdD;
    end
  end

  // Pipeline registers; nothing below D ever stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= '{reg_write: e_q.reg_write, result_src: e_q.result_src,
               mem_write: e_q.mem_write, rd: e_q.rd};
      w_q <= '{reg_write: m_q.reg_write, result_src: m_q.result_src, rd: m_q.rd};
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (lw_stall && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (pc_src && (flush_q != {CNT_W{1'b1}})) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.ResultSrcE  = e_q.result_src;
  assign bus.MemWriteE   = e_q.mem_write;
  assign bus.AluSrcE     = e_q.alu_src;
  assign bus.AluControlE = e_q.alu_control;
  assign bus.Rs1E        = e_q.rs1;
  assign bus.Rs2E        = e_q.rs2;
  assign bus.RdE         = e_q.rd;

  assign bus.RegWriteM   = m_q.reg_write;
  assign bus.ResultSrcM  = m_q.result_src;
  assign bus.MemWriteM   = m_q.mem_write;
  assign bus.RdM         = m_q.rd;

  assign bus.RegWriteW   = w_q.reg_write;
  assign bus.ResultSrcW  = w_q.result_src;
  assign bus.RdW         = w_q.rd;

  assign bus.PCSrcE      = pc_src;
  assign bus.ForwardAE   = fwd_a;
  assign bus.ForwardBE   = fwd_b;
  assign bus.StallF      = lw_stall;
  assign bus.StallD      = lw_stall;
  assign bus.FlushD      = pc_src;
  assign bus.FlushE      = flush_e;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, forwarding, flushes, counters, reset.
module tb_pipe_hazard_ctrl;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALUCTL_W = 3;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned CNT_W_SM = 2;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .ALUCTL_W(ALUCTL_W), .CNT_W(CNT_W))    bus ();
  pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .ALUCTL_W(ALUCTL_W), .CNT_W(CNT_W_SM)) bus2 ();

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .ALUCTL_W(ALUCTL_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .ALUCTL_W(ALUCTL_W), .CNT_W(CNT_W_SM)) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [1:0] rs, input logic mw, input logic j,
                       input logic b, input logic as, input logic [2:0] ac,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    bus.RegWriteD   = rw;
    bus.ResultSrcD  = rs;
    bus.MemWriteD   = mw;
    bus.JumpD       = j;
    bus.BranchD     = b;
    bus.AluSrcD     = as;
    bus.AluControlD = ac;
    bus.Rs1D        = r1;
    bus.Rs2D        = r2;
    bus.RdD         = rd;
  endtask

  task automatic drive2(input logic rw, input logic [1:0] rs, input logic [4:0] r1,
                        input logic [4:0] rd);
    bus2.RegWriteD   = rw;
    bus2.ResultSrcD  = rs;
    bus2.MemWriteD   = 1'b0;
    bus2.JumpD       = 1'b0;
    bus2.BranchD     = 1'b0;
    bus2.AluSrcD     = 1'b0;
    bus2.AluControlD = 3'd0;
    bus2.Rs1D        = r1;
    bus2.Rs2D        = 5'd0;
    bus2.RdD         = rd;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
    bus.ZeroE = 1'b0;
    drive2(0, 2'b00, 5'd0, 5'd0);
    bus2.ZeroE = 1'b0;
    repeat (2) tick();

    // reset state
    chk("rst_RegWriteE", 32'(bus.RegWriteE), 0);
    chk("rst_RegWriteW", 32'(bus.RegWriteW), 0);
    chk("rst_RdE",       32'(bus.RdE), 0);
    chk("rst_PCSrcE",    32'(bus.PCSrcE), 0);
    chk("rst_StallF",    32'(bus.StallF), 0);
    chk("rst_FlushE",    32'(bus.FlushE), 0);
    chk("rst_ForwardAE", 32'(bus.ForwardAE), 0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    chk("rst_flush_cnt", 32'(bus.flush_cnt), 0);
    reset = 1'b1;
    tick();

    // load-use: lw x5 then add x8, x5, x6
    drive(1, 2'b01, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd5);
    #1;
    chk("lw_no_stall_empty", 32'(bus.StallF), 0);
    tick();
    chk("lw_RdE",        32'(bus.RdE), 5);
    chk("lw_ResultSrcE", 32'(bus.ResultSrcE), 1);
    chk("lw_RegWriteE",  32'(bus.RegWriteE), 1);
    drive(1, 2'b00, 0, 0, 0, 0, 3'd2, 5'd5, 5'd6, 5'd8);
    #1;
    chk("lu_StallF", 32'(bus.StallF), 1);
    chk("lu_StallD", 32'(bus.StallD), 1);
    chk("lu_FlushE", 32'(bus.FlushE), 1);
    chk("lu_FlushD", 32'(bus.FlushD), 0);
    tick();
    chk("bub_RegWriteE",   32'(bus.RegWriteE), 0);
    chk("bub_RdE",         32'(bus.RdE), 0);
    chk("bub_AluControlE", 32'(bus.AluControlE), 0);
    chk("bub_RdM",         32'(bus.RdM), 5);
    chk("bub_RegWriteM",   32'(bus.RegWriteM), 1);
    chk("bub_StallF",      32'(bus.StallF), 0);
    chk("lu_stall_cnt",    32'(bus.stall_cnt), 1);
    tick();
    chk("add_Rs1E",        32'(bus.Rs1E), 5);
    chk("add_Rs2E",        32'(bus.Rs2E), 6);
    chk("add_RdE",         32'(bus.RdE), 8);
    chk("add_AluControlE", 32'(bus.AluControlE), 2);
    chk("add_ForwardAE",   32'(bus.ForwardAE), 1);
    chk("add_ForwardBE",   32'(bus.ForwardBE), 0);
    chk("add_RdW",         32'(bus.RdW), 5);
    chk("add_ResultSrcW",  32'(bus.ResultSrcW), 1);

    // M and W both write x7: M wins
    drive(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd7);
    tick();
    tick();
    drive(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd7, 5'd7, 5'd9);
    tick();
    chk("mw_ForwardAE", 32'(bus.ForwardAE), 2);
    chk("mw_ForwardBE", 32'(bus.ForwardBE), 2);
    drive(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd9, 5'd7, 5'd10);
    tick();
    chk("mix_ForwardAE", 32'(bus.ForwardAE), 2);
    chk("mix_ForwardBE", 32'(bus.ForwardBE), 1);

    // x0 is never a hazard source
    drive(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd1, 5'd1, 5'd0);
    tick();
    drive(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd3);
    tick();
    chk("x0_RegWriteM", 32'(bus.RegWriteM), 1);
    chk("x0_ForwardAE", 32'(bus.ForwardAE), 0);
    chk("x0_ForwardBE", 32'(bus.ForwardBE), 0);
    drive(1, 2'b01, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1, 2'b00, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd4);
    #1;
    chk("x0_StallF", 32'(bus.StallF), 0);
    chk("x0_FlushE", 32'(bus.FlushE), 0);
    tick();
    chk("x0_stall_cnt", 32'(bus.stall_cnt), 1);

    // taken beq
    drive(0, 2'b00, 0, 0, 1, 0, 3'd0, 5'd1, 5'd2, 5'd0);
    tick();
    bus.ZeroE = 1'b1;
    drive(1, 2'b00, 0, 0, 0, 1, 3'd7, 5'd3, 5'd4, 5'd4);
    #1;
    chk("br_PCSrcE", 32'(bus.PCSrcE), 1);
    chk("br_FlushD", 32'(bus.FlushD), 1);
    chk("br_FlushE", 32'(bus.FlushE), 1);
    chk("br_StallF", 32'(bus.StallF), 0);
    tick();
    chk("brf_RegWriteE",   32'(bus.RegWriteE), 0);
    chk("brf_AluSrcE",     32'(bus.AluSrcE), 0);
    chk("brf_AluControlE", 32'(bus.AluControlE), 0);
    chk("brf_RdE",         32'(bus.RdE), 0);
    chk("brf_Rs1E",        32'(bus.Rs1E), 0);
    chk("brf_PCSrcE",      32'(bus.PCSrcE), 0);
    chk("br_flush_cnt",    32'(bus.flush_cnt), 1);

    // not-taken beq
    drive(0, 2'b00, 0, 0, 1, 0, 3'd0, 5'd1, 5'd2, 5'd0);
    tick();
    bus.ZeroE = 1'b0;
    drive(1, 2'b00, 0, 0, 0, 1, 3'd7, 5'd3, 5'd4, 5'd4);
    #1;
    chk("nt_PCSrcE", 32'(bus.PCSrcE), 0);
    chk("nt_FlushE", 32'(bus.FlushE), 0);
    tick();
    chk("nt_RegWriteE",   32'(bus.RegWriteE), 1);
    chk("nt_RdE",         32'(bus.RdE), 4);
    chk("nt_AluControlE", 32'(bus.AluControlE), 7);
    chk("nt_AluSrcE",     32'(bus.AluSrcE), 1);
    chk("nt_flush_cnt",   32'(bus.flush_cnt), 1);

    // jal x1 flushes regardless of ZeroE
    drive(1, 2'b10, 0, 1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd1);
    tick();
    chk("jal_PCSrcE", 32'(bus.PCSrcE), 1);
    drive(0, 2'b00, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("jal_flush_cnt", 32'(bus.flush_cnt), 2);
    chk("jal_RdM",       32'(bus.RdM), 1);
    chk("jal_ResultSrcM", 32'(bus.ResultSrcM), 2);

    // store propagates MemWrite E->M
    drive(0, 2'b00, 1, 0, 0, 1, 3'd0, 5'd2, 5'd3, 5'd0);
    tick();
    chk("sw_MemWriteE", 32'(bus.MemWriteE), 1);
    drive(0, 2'b00, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("sw_MemWriteM", 32'(bus.MemWriteM), 1);
    chk("sw_MemWriteE0", 32'(bus.MemWriteE), 0);

    // 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      drive2(1, 2'b01, 5'd0, 5'd5);
      tick();
      drive2(1, 2'b00, 5'd5, 5'd6);
      #1;
      chk("sat_StallF", 32'(bus2.StallF), 1);
      tick();
      chk("sat_stall_cnt", 32'(bus2.stall_cnt), (i < 3) ? (i + 1) : 3);
    end

    // random traffic, then asynchronous reset mid-cycle
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      bus.ZeroE = 1'($urandom);
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    chk("ar_RegWriteE",   32'(bus.RegWriteE), 0);
    chk("ar_RegWriteM",   32'(bus.RegWriteM), 0);
    chk("ar_RegWriteW",   32'(bus.RegWriteW), 0);
    chk("ar_ResultSrcE",  32'(bus.ResultSrcE), 0);
    chk("ar_ResultSrcW",  32'(bus.ResultSrcW), 0);
    chk("ar_MemWriteE",   32'(bus.MemWriteE), 0);
    chk("ar_AluControlE", 32'(bus.AluControlE), 0);
    chk("ar_Rs1E",        32'(bus.Rs1E), 0);
    chk("ar_Rs2E",        32'(bus.Rs2E), 0);
    chk("ar_RdE",         32'(bus.RdE), 0);
    chk("ar_RdM",         32'(bus.RdM), 0);
    chk("ar_RdW",         32'(bus.RdW), 0);
    chk("ar_PCSrcE",      32'(bus.PCSrcE), 0);
    chk("ar_ForwardAE",   32'(bus.ForwardAE), 0);
    chk("ar_ForwardBE",   32'(bus.ForwardBE), 0);
    chk("ar_StallF",      32'(bus.StallF), 0);
    chk("ar_FlushE",      32'(bus.FlushE), 0);
    chk("ar_stall_cnt",   32'(bus.stall_cnt), 0);
    chk("ar_flush_cnt",   32'(bus.flush_cnt), 0);
    chk("ar_stall_cnt2",  32'(bus2.stall_cnt), 0);
    tick();
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
